dtoe_elastic_reg: RTL and testbench

//  Parametrised decode-to-execute pipeline register with valid/ready handshake and 2-entry skid buffer.

---
 rtl/dtoe_elastic_reg.sv | 140 ++++++++++++++
 tb/tb_dtoe_elastic_reg.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dtoe_elastic_reg.sv
// Decode-to-execute pipeline register: valid/ready handshake with a 2-entry skid buffer.
// Latency 1 cycle D->E. Registered ReadyD drops only when both entries are full.
module dtoe_elastic_reg #(
  parameter int WIDTH  = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              DTOEER_CLK,
  input  logic              DTOEER_RST,
  input  logic              DTOEER_CLR,
  input  logic              DTOEER_ValidD,
  output logic              DTOEER_ReadyD,
  input  logic [WIDTH-1:0]  DTOEER_RD1D,
  input  logic [WIDTH-1:0]  DTOEER_RD2D,
  input  logic [RA_W-1:0]   DTOEER_RsD,
  input  logic [RA_W-1:0]   DTOEER_RtD,
  input  logic [RA_W-1:0]   DTOEER_RdD,
  input  logic [WIDTH-1:0]  DTOEER_SignImmD,
  input  logic [CTRL_W-1:0] DTOEER_CtrlD,
  output logic              DTOEER_ValidE,
  input  logic              DTOEER_ReadyE,
  output logic [WIDTH-1:0]  DTOEER_RD1E,
  output logic [WIDTH-1:0]  DTOEER_RD2E,
  output logic [RA_W-1:0]   DTOEER_RsE,
  output logic [RA_W-1:0]   DTOEER_RtE,
  output logic [RA_W-1:0]   DTOEER_RdE,
  output logic [WIDTH-1:0]  DTOEER_SignImmE,
  output logic [CTRL_W-1:0] DTOEER_CtrlE,
  output logic [CNT_W-1:0]  DTOEER_BubbleCnt
);

  typedef struct packed {
    logic [WIDTH-1:0]  rd1;
    logic [WIDTH-1:0]  rd2;
    logic [WIDTH-1:0]  imm;
    logic [RA_W-1:0]   rs;
    logic [RA_W-1:0]   rt;
    logic [RA_W-1:0]   rd;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]       state_q, state_d;
  entry_t           head_q, head_d;
  entry_t           skid_q, skid_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  entry_t           d_ent;
  logic             accept, issue;

  assign d_ent = '{rd1: DTOEER_RD1D, rd2: DTOEER_RD2D, imm: DTOEER_SignImmD,
                   rs: DTOEER_RsD, rt: DTOEER_RtD, rd: DTOEER_RdD, ctrl: DTOEER_CtrlD};

  assign accept = DTOEER_ValidD & ready_q;
  assign issue  = (state_q != S_EMPTY) & DTOEER_ReadyE;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (DTOEER_CLR) begin
      state_d = S_EMPTY;
      head_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d = S_ONE;
            head_d  = d_ent;
          end
        end
        S_ONE: begin
          if (accept && issue) begin
            head_d = d_ent;
          end else if (issue) begin
            // Clearing the head on drain keeps the E side a NOP bubble.
            state_d = S_EMPTY;
            head_d  = '0;
          end else if (accept) begin
            state_d = S_TWO;
            skid_d  = d_ent;
          end
        end
        S_TWO: begin
          if (issue) begin
            state_d = S_ONE;
            head_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = S_EMPTY;
          head_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
    ready_d = (state_d != S_TWO);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (DTOEER_ReadyE && (state_q == S_EMPTY) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge DTOEER_CLK) begin
    if (DTOEER_RST) begin
      state_q <= S_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  assign DTOEER_ReadyD    = ready_q;
  assign DTOEER_ValidE    = (state_q != S_EMPTY);
  assign DTOEER_RD1E      = head_q.rd1;
  assign DTOEER_RD2E      = head_q.rd2;
  assign DTOEER_RsE       = head_q.rs;
  assign DTOEER_RtE       = head_q.rt;
  assign DTOEER_RdE       = head_q.rd;
  assign DTOEER_SignImmE  = head_q.imm;
  assign DTOEER_CtrlE     = head_q.ctrl;
  assign DTOEER_BubbleCnt = cnt_q;

endmodule

// File: tb/tb_dtoe_elastic_reg.sv
// Directed bench for dtoe_elastic_reg (CNT_W=4 so counter saturation is reachable quickly).
// Checks run on registered outputs one time unit after each rising edge.
// Back-pressure is driven directly by the bench through ready_e.
module tb_dtoe_elastic_reg;
    localparam int WIDTH = 32, RA_W = 5, CTRL_W = 8, CNT_W = 4;

    logic              clk = 1'b0;
    logic              rst, clr, valid_d, ready_e;
    logic              ready_d, valid_e;
    logic [WIDTH-1:0]  rd1_d, rd2_d, imm_d, rd1_e, rd2_e, imm_e;
    logic [RA_W-1:0]   rs_d, rt_d, rdd_d, rs_e, rt_e, rdd_e;
    logic [CTRL_W-1:0] ctrl_d, ctrl_e;
    logic [CNT_W-1:0]  bcnt;
    int                n_chk = 0;
    int                n_fail = 0;

    always #5 clk = ~clk;

    dtoe_elastic_reg #(.WIDTH(WIDTH), .RA_W(RA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .DTOEER_CLK(clk), .DTOEER_RST(rst), .DTOEER_CLR(clr),
        .DTOEER_ValidD(valid_d), .DTOEER_ReadyD(ready_d),
        .DTOEER_RD1D(rd1_d), .DTOEER_RD2D(rd2_d), .DTOEER_RsD(rs_d), .DTOEER_RtD(rt_d),
        .DTOEER_RdD(rdd_d), .DTOEER_SignImmD(imm_d), .DTOEER_CtrlD(ctrl_d),
        .DTOEER_ValidE(valid_e), .DTOEER_ReadyE(ready_e),
        .DTOEER_RD1E(rd1_e), .DTOEER_RD2E(rd2_e), .DTOEER_RsE(rs_e), .DTOEER_RtE(rt_e),
        .DTOEER_RdE(rdd_e), .DTOEER_SignImmE(imm_e), .DTOEER_CtrlE(ctrl_e),
        .DTOEER_BubbleCnt(bcnt)
    );

    function automatic logic [CTRL_W-1:0] ctrl_of(input logic [31:0] x);
        return x[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [RA_W-1:0] rs_of(input logic [31:0] x);
        return x[4:0] + 5'd3;
    endfunction

    task automatic send(input logic v, input logic [31:0] x);
        valid_d = v;
        rd1_d   = x;
        rd2_d   = ~x;
        imm_d   = x + 32'h100;
        rs_d    = rs_of(x);
        rt_d    = x[4:0] ^ 5'h11;
        rdd_d   = ~x[4:0];
        ctrl_d  = ctrl_of(x);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_entry(input string tag, input logic [31:0] x);
        n_chk++;
        if (valid_e !== 1'b1) fail({tag, ".valid"}, 32'(valid_e), 32'h1);
        n_chk++;
        if (rd1_e !== x) fail({tag, ".rd1"}, rd1_e, x);
        n_chk++;
        if (rd2_e !== ~x) fail({tag, ".rd2"}, rd2_e, ~x);
        n_chk++;
        if (imm_e !== (x + 32'h100)) fail({tag, ".imm"}, imm_e, x + 32'h100);
        n_chk++;
        if (rs_e !== rs_of(x)) fail({tag, ".rs"}, 32'(rs_e), 32'(rs_of(x)));
        n_chk++;
        if (ctrl_e !== ctrl_of(x)) fail({tag, ".ctrl"}, 32'(ctrl_e), 32'(ctrl_of(x)));
    endtask

    task automatic chk_bubble(input string tag);
        n_chk++;
        if (valid_e !== 1'b0) fail({tag, ".valid"}, 32'(valid_e), 32'h0);
        n_chk++;
        if (rd1_e !== 32'h0) fail({tag, ".rd1"}, rd1_e, 32'h0);
        n_chk++;
        if (rd2_e !== 32'h0) fail({tag, ".rd2"}, rd2_e, 32'h0);
        n_chk++;
        if (imm_e !== 32'h0) fail({tag, ".imm"}, imm_e, 32'h0);
        n_chk++;
        if (rs_e !== 5'h0) fail({tag, ".rs"}, 32'(rs_e), 32'h0);
        n_chk++;
        if (rt_e !== 5'h0) fail({tag, ".rt"}, 32'(rt_e), 32'h0);
        n_chk++;
        if (rdd_e !== 5'h0) fail({tag, ".rd"}, 32'(rdd_e), 32'h0);
        n_chk++;
        if (ctrl_e !== 8'h0) fail({tag, ".ctrl"}, 32'(ctrl_e), 32'h0);
    endtask

    task automatic chk_ready(input string tag, input logic exp);
        n_chk++;
        if (ready_d !== exp) fail(tag, 32'(ready_d), 32'(exp));
    endtask

    task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] exp);
        n_chk++;
        if (bcnt !== exp) fail(tag, 32'(bcnt), 32'(exp));
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            send(1'($urandom_range(0, 1)), $urandom);
            ready_e = 1'($urandom_range(0, 1));
            step();
        end
        chk_bubble("rst");
        chk_ready("rst.ready_d", 1'b1);
        chk_cnt("rst.bcnt", 4'd0);

        rst = 1'b0;
        send(1'b0, 32'h0);
        ready_e = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk_cnt("bub.cnt5", 4'd5);
        for (int i = 0; i < 15; i++) step();
        chk_cnt("bub.cnt20", 4'd15);
        step();
        chk_cnt("bub.hold", 4'd15);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk_cnt("bub.clr", 4'd15);

        for (int i = 1; i <= 8; i++) begin
            send(1'b1, 32'(i));
            step();
            chk_entry($sformatf("strm%0d", i), 32'(i));
            chk_ready("strm.ready_d", 1'b1);
        end
        send(1'b0, 32'h0);
        step();
        chk_bubble("strm.drain");

        ready_e = 1'b0;
        send(1'b1, 32'hA);
        step();
        chk_entry("bp.a0", 32'hA);
        chk_ready("bp.ready_a", 1'b1);
        send(1'b1, 32'hB);
        step();
        chk_entry("bp.a1", 32'hA);
        chk_ready("bp.ready_b", 1'b0);
        send(1'b1, 32'hC);
        step();
        chk_entry("bp.a2", 32'hA);
        chk_ready("bp.ready_c", 1'b0);
        ready_e = 1'b1;
        step();
        chk_entry("bp.b", 32'hB);
        chk_ready("bp.ready_rel", 1'b1);
        step();
        chk_entry("bp.c", 32'hC);
        send(1'b0, 32'h0);
        step();
        chk_bubble("bp.drain");

        ready_e = 1'b0;
        send(1'b1, 32'h1A);
        step();
        send(1'b1, 32'h1B);
        step();
        chk_ready("fl.full", 1'b0);
        send(1'b1, 32'h1C);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk_bubble("fl.post");
        chk_ready("fl.ready_d", 1'b1);
        send(1'b0, 32'h0);
        ready_e = 1'b1;
        step();
        chk_bubble("fl.noc");

        ready_e = 1'b0;
        send(1'b1, 32'h2A);
        step();
        chk_entry("sim.a", 32'h2A);
        ready_e = 1'b1;
        send(1'b1, 32'h2B);
        step();
        chk_entry("sim.b", 32'h2B);
        chk_ready("sim.ready_d", 1'b1);
        send(1'b0, 32'h0);
        step();
        chk_bubble("sim.drain");

        ready_e = 1'b0;
        send(1'b1, 32'h3A);
        step();
        send(1'b1, 32'h3B);
        step();
        rst = 1'b1;
        send(1'b0, 32'h0);
        step();
        chk_bubble("mrst");
        chk_ready("mrst.ready_d", 1'b1);
        chk_cnt("mrst.bcnt", 4'd0);
        rst = 1'b0;
        ready_e = 1'b1;
        step();
        chk_bubble("mrst.after");
        chk_cnt("mrst.bcnt1", 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end
endmodule
